// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT ping-pong sample buffers.
package fft_buf_pkg;

  localparam int unsigned CPLX_NB      = 16;
  localparam int unsigned BITREV_MAX_W = 16;

  // Complex sample at the pipeline's standard width
  typedef struct packed {
    logic [CPLX_NB-1:0] re;
    logic [CPLX_NB-1:0] im;
  } cplx_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Reverse the low w bits of a; bits at and above w come back as zero
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] a,
                                                     input int unsigned w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[i] = a[w - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pp_dpram.sv
// Simple dual-port RAM for both ping-pong banks: 2*DEPTH words of {re,im}.
// Address is {bank, index}; the read port has a registered output.
module pp_dpram #(
  parameter int unsigned NB     = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [2*NB-1:0]   wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [2*NB-1:0]   rdata
);

  localparam int unsigned WORDS = 2 << ADDR_W;

  logic [2*NB-1:0] mem [WORDS];

  // Write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds its value while re is low
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_cbuf.sv
// Two-bank (ping-pong) complex sample buffer: frames the input stream into
// DEPTH-sample blocks and replays each block with a START pulse.
// Build option: define FFT_BUF_BITREV_EN to read each bank in bit-reversed
// index order (FFT output reordering); otherwise natural order.
module pingpong_cbuf
  import fft_buf_pkg::*;
#(
  parameter int unsigned NB     = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ED,
  input  logic          WV,
  input  logic [NB-1:0] DR,
  input  logic [NB-1:0] DI,
  output logic          START,
  output logic          RV,
  output logic [NB-1:0] DOR,
  output logic [NB-1:0] DOI,
  output logic          OVF,
  output logic          IDLE
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wcnt, rcnt, rcnt_next, rd_idx;
  logic              wbank, rbank;
  logic [1:0]        full;
  rd_state_t         rd_state, rd_next;
  logic              issue, rd_done;
  logic              wr_ok, wr_last, ovf_hit, ovf_q;
  logic [ADDR_W:0]   raddr_q;
  logic              v1_q, s1_q, rv_q, start_q;
  logic [2*NB-1:0]   rdata;

  assign wr_ok   = ED & WV & ~full[wbank];
  assign wr_last = wr_ok & (wcnt == LAST);
  assign ovf_hit = ED & WV & full[wbank];

  // Reader next-state: one IDLE cycle before a frame, none between back-to-back frames.
  // The continuation check also sees a fill landing this same cycle so streams stay gapless.
  always_comb begin
    rd_next   = rd_state;
    rcnt_next = rcnt;
    issue     = 1'b0;
    rd_done   = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        if (full[rbank]) begin
          rd_next   = RD_READ;
          rcnt_next = '0;
        end
      end
      RD_READ: begin
        issue     = 1'b1;
        rcnt_next = rcnt + 1'b1;
        if (rcnt == LAST) begin
          rd_done   = 1'b1;
          rcnt_next = '0;
          if (!(full[~rbank] | (wr_last & (wbank != rbank)))) rd_next = RD_IDLE;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Reader state, read counter and bank pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_state <= RD_IDLE;
      rcnt     <= '0;
      rbank    <= 1'b0;
    end else if (ED) begin
      rd_state <= rd_next;
      rcnt     <= rcnt_next;
      if (rd_done) rbank <= ~rbank;
    end
  end

  // Writer counter, bank pointer and sticky overflow
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wcnt <= wcnt + 1'b1;
        if (wr_last) wbank <= ~wbank;
      end
      if (ovf_hit) ovf_q <= 1'b1;
    end
  end

  // Bank ownership: set by the writer on the last sample, cleared by the reader on release
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full <= '0;
    end else if (ED) begin
      if (rd_done) full[rbank] <= 1'b0;
      if (wr_last) full[wbank] <= 1'b1;
    end
  end

`ifdef FFT_BUF_BITREV_EN
  assign rd_idx = ADDR_W'(bitrev(BITREV_MAX_W'(rcnt), ADDR_W));
`else
  assign rd_idx = rcnt;
`endif

  // Address register plus valid/START pipe aligned with the RAM output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      raddr_q <= '0;
      v1_q    <= 1'b0;
      s1_q    <= 1'b0;
      rv_q    <= 1'b0;
      start_q <= 1'b0;
    end else if (ED) begin
      if (issue) raddr_q <= {rbank, rd_idx};
      v1_q    <= issue;
      s1_q    <= issue & (rcnt == '0);
      rv_q    <= v1_q;
      start_q <= s1_q;
    end
  end

  pp_dpram #(
    .NB     (NB),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK   (CLK),
    .RST   (RST),
    .we    (wr_ok),
    .waddr ({wbank, wcnt}),
    .wdata ({DR, DI}),
    .re    (ED & v1_q),
    .raddr (raddr_q),
    .rdata (rdata)
  );

  assign {DOR, DOI} = rdata;
  assign START      = start_q;
  assign RV         = rv_q;
  assign OVF        = ovf_q;
  assign IDLE       = ~full[0] & ~full[1] & (rd_state == RD_IDLE) & ~v1_q & ~rv_q;

endmodule
